// File: rtl/tl_ul_mem_responder_if.sv
// tl_ul_mem_responder_if: TileLink-UL A/D channel bundle; the master drives A fields and d_ready, the slave drives D fields and a_ready
interface tl_ul_mem_responder_if #(
  parameter int SRC_W  = 3,
  parameter int SIZE_W = 2
);
  logic              a_valid;
  logic              a_ready;
  logic [2:0]        a_opcode;
  logic [2:0]        a_param;
  logic [SIZE_W-1:0] a_size;
  logic [SRC_W-1:0]  a_source;
  logic [31:0]       a_address;
  logic [3:0]        a_mask;
  logic [31:0]       a_data;
  logic              a_corrupt;
  logic              d_valid;
  logic              d_ready;
  logic [2:0]        d_opcode;
  logic [1:0]        d_param;
  logic [SIZE_W-1:0] d_size;
  logic [SRC_W-1:0]  d_source;
  logic              d_sink;
  logic              d_denied;
  logic [31:0]       d_data;
  logic              d_corrupt;
  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, d_ready,
    input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt
  );
  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, d_ready,
    output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt
  );
endinterface

// File: rtl/tl_ul_mem_responder.sv
// tl_ul_mem_responder: TileLink-UL manager turning Get/PutFull/PutPartial on tl (slave modport) into mem_* accesses on a fixed-latency word RAM; clock/reset sync active-high
module tl_ul_mem_responder #(
  parameter int          SRC_W   = 3,
  parameter int          SIZE_W  = 2,
  parameter logic [31:0] BASE    = 32'h0000_0000,
  parameter int          MEM_AW  = 10,
  parameter int          LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  tl_ul_mem_responder_if.slave tl,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic [31:0]       mem_rdata
);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  state_t state, state_next;
  logic [2:0]        op;
  logic [3:0]        mask;
  logic [31:0]       data;
  logic              corrupt;
  logic [MEM_AW-1:0] idx;
  logic [CW-1:0]     cnt;
  logic [32:0]       off;
  logic [1:0]        amask;
  logic              fire, deny, is_get, wait_done;
  logic [2:0]        d_opcode;
  logic [SIZE_W-1:0] d_size;
  logic [SRC_W-1:0]  d_source;
  logic              d_denied, d_corrupt;
  logic [31:0]       d_data;
  always_comb begin
    fire       = tl.a_valid && state == IDLE;
    off        = {1'b0, tl.a_address} - {1'b0, BASE};
    amask      = tl.a_size == SIZE_W'(2) ? 2'd3 : tl.a_size == SIZE_W'(1) ? 2'd1 : 2'd0;
    deny       = !(tl.a_opcode inside {3'd0, 3'd1, 3'd4}) || tl.a_size > SIZE_W'(2) ||
                 |(tl.a_address[1:0] & amask) || off >= (33'd4 << MEM_AW);
    is_get     = op == 3'd4;
    wait_done  = cnt == CW'(LATENCY - 1);
    state_next = state == IDLE   ? (fire ? (deny ? RESP : ACCESS) : IDLE) :
                 state == ACCESS ? (is_get ? WAIT : RESP) :
                 state == WAIT   ? (wait_done ? RESP : WAIT) :
                 (tl.d_ready ? IDLE : RESP);
  end
  always_ff @(posedge clock) state <= reset ? IDLE : state_next;
  always_ff @(posedge clock) begin
    if (reset) begin
      op        <= '0;
      mask      <= '0;
      data      <= '0;
      corrupt   <= 1'b0;
      idx       <= '0;
      cnt       <= '0;
      d_opcode  <= '0;
      d_size    <= '0;
      d_source  <= '0;
      d_denied  <= 1'b0;
      d_corrupt <= 1'b0;
      d_data    <= '0;
    end else begin
      if (fire) begin
        op        <= tl.a_opcode;
        mask      <= tl.a_mask;
        data      <= tl.a_data;
        corrupt   <= tl.a_corrupt;
        idx       <= off[MEM_AW+1:2];
        d_opcode  <= {2'b0, tl.a_opcode == 3'd4};
        d_size    <= tl.a_size;
        d_source  <= tl.a_source;
        d_denied  <= deny;
        d_corrupt <= deny && tl.a_opcode == 3'd4;
        d_data    <= '0;
      end
      cnt <= state == WAIT ? cnt + 1'b1 : '0;
      if (state == WAIT && wait_done) d_data <= mem_rdata;
    end
  end
  assign mem_en       = state == ACCESS && (is_get || !corrupt);
  assign mem_we       = mem_en && !is_get;
  assign mem_addr     = mem_en ? idx : '0;
  assign mem_wdata    = mem_we ? data : '0;
  assign mem_wmask    = mem_we ? mask : '0;
  assign tl.a_ready   = state == IDLE;
  assign tl.d_valid   = state == RESP;
  assign tl.d_opcode  = d_opcode;
  assign tl.d_param   = 2'd0;
  assign tl.d_size    = d_size;
  assign tl.d_source  = d_source;
  assign tl.d_sink    = 1'b0;
  assign tl.d_denied  = d_denied;
  assign tl.d_data    = d_data;
  assign tl.d_corrupt = d_corrupt;
endmodule

// File: doc/tl_ul_mem_responder.md
Name: tl_ul_mem_responder

Overview:
TileLink-UL responder (manager side) that accepts A-channel requests from an upstream initiator and returns D-channel responses. Get, PutFullData and PutPartialData requests are translated into accesses on a single-port, fixed-latency, word-wide memory. The block sits at the far end of an A-source/D-sink master port, for example as the endpoint behind a crossbar for scratchpad or register-file RAM. It supports one outstanding request at a time.

Parameters:
SRC_W, 3, width of a_source/d_source
SIZE_W, 2, width of a_size/d_size
BASE, 32'h0000_0000, base byte address of the mapped region
MEM_AW, 10, log2 of the memory depth in 32-bit words; region size = 4<<MEM_AW bytes
LATENCY, 1, memory read latency in cycles (>=1)

Ports:
clock  in  1  sole clock
reset  in  1  synchronous, active-high reset
a_valid  in  1  A request valid
a_ready  out  1  A request ready
a_opcode  in  3  0=PutFull, 1=PutPartial, 4=Get; others unsupported
a_param  in  3  ignored
a_size  in  SIZE_W  log2 of bytes
a_source  in  SRC_W  request ID
a_address  in  32  byte address
a_mask  in  4  byte lanes
a_data  in  32  write data
a_corrupt  in  1  write data corrupt
d_valid  out  1  D response valid
d_ready  in  1  D response ready
d_opcode  out  3  0=AccessAck, 1=AccessAckData
d_param  out  2  always 0
d_size  out  SIZE_W  echo of a_size
d_source  out  SRC_W  echo of a_source
d_sink  out  1  always 0
d_denied  out  1  request rejected
d_data  out  32  read data
d_corrupt  out  1  read data invalid
mem_en  out  1  memory access strobe
mem_we  out  1  write enable
mem_addr  out  MEM_AW  word index = (a_address-BASE)>>2
mem_wdata  out  32  write data
mem_wmask  out  4  byte write mask
mem_rdata  in  32  valid LATENCY cycles after a read mem_en

Behaviour:
- Clock and reset: one clock, `clock`. `reset` is synchronous and active-high.
- Reset values: state=IDLE; a_ready=1; d_valid=0; mem_en=0; mem_we=0. All D payload registers are 0.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE: a_ready=1. On A fire (cycle N), capture opcode, size, source, mask, data and corrupt. Then evaluate deny:
  - Deny conditions: opcode not in {0,1,4}; a_size>2; a_address misaligned to 1<<a_size; address outside [BASE, BASE+(4<<MEM_AW)).
  - Denied request: go to RESP (d_valid in cycle N+1) with d_denied=1.
  - Denied Get: d_opcode=1, d_data=0, d_corrupt=1.
  - Denied Put: d_opcode=0, d_corrupt=0.
  - Otherwise: go to ACCESS.
- ACCESS (one cycle, N+1): mem_en=1 and mem_addr driven.
  - Put: mem_we=1, mem_wdata=a_data, mem_wmask=a_mask. If a_corrupt=1, mem_en=0 and the write is suppressed; the response is still a normal AccessAck with denied=0. Next state RESP, so d_valid is asserted at N+2.
  - Get: mem_we=0, mem_wmask=0. Next state WAIT.
- WAIT: counter counts LATENCY cycles. mem_rdata is captured into d_data in cycle N+1+LATENCY. Next state RESP, so d_valid is asserted at N+2+LATENCY. Response: d_opcode=1, d_corrupt=0, d_denied=0.
- RESP: d_valid=1.
  - All D fields are registered and stable while d_valid=1 && d_ready=0.
  - On d_ready, return to IDLE; a_ready=1 in the following cycle. There is no A/D overlap.
- Other D fields: d_param=0; d_sink=0; d_size and d_source echo the captured request.
- a_ready=0 in every state except IDLE. A-channel inputs are sampled only at fire.
- mem_en is a single-cycle pulse per access; mem_* outputs are 0 whenever mem_en=0.
- Sub-word Get returns the full 32-bit word; lane selection is the initiator's job.
- PutPartial with a_mask=0: mem_en=1 with mem_wmask=0, and AccessAck is returned.
- Reset mid-transaction: the next cycle is in IDLE, d_valid=0, mem_en=0. The in-flight request is dropped and no response is issued.
- Back-to-back requests: the second A fire occurs no earlier than the cycle after D fire.

Test Plan:
- Put then Get: PutFull addr BASE+8, data 32'hDEADBEEF, mask 4'hF, source 5 -> mem_en/mem_we pulse at N+1 with mem_addr=2, AccessAck source 5 at N+2. Get of the same address with LATENCY=1 -> AccessAckData, d_data=32'hDEADBEEF, d_valid at N+3.
- PutPartial: mask 4'b0011, data 32'h0000_1234 -> mem_wmask=4'b0011. A later Get returns 32'hDEAD1234 against a behavioural RAM model.
- Deny cases, each giving d_denied=1 with d_valid at N+1 and no mem_en:
  - addr BASE+(4<<MEM_AW);
  - opcode 2;
  - Get size 2 at addr BASE+2 (response has d_corrupt=1, d_data=0).
- D backpressure: hold d_ready=0 for 5 cycles during a Get response -> d_valid and all D fields stable, a_ready=0. On release, one D fire, then a_ready=1 the next cycle.
- Corrupt write: PutFull with a_corrupt=1 -> no mem_en, AccessAck with denied=0. A follow-up Get returns the old data.
- Reset in WAIT with LATENCY=3: reset asserted during WAIT -> next cycle d_valid=0, a_ready=1, and no response for the dropped request ever appears.
